// File: rtl/vector_lane_engine_pkg.sv
// Shared encodings for the vector lane engine: ops, element widths, FSM states
// and small element-width helpers.
package vector_lane_engine_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_AND    = 3'd2,
    OP_OR     = 3'd3,
    OP_XOR    = 3'd4,
    OP_MINU   = 3'd5,
    OP_MAXU   = 3'd6,
    OP_REDSUM = 3'd7
  } op_e;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] sew_bytes(input logic [1:0] sew);
    return 4'd1 << sew;
  endfunction

  function automatic logic [63:0] sew_mask(input logic [1:0] sew);
    case (sew)
      SEW_8:   return 64'h0000_0000_0000_00FF;
      SEW_16:  return 64'h0000_0000_0000_FFFF;
      SEW_32:  return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/vector_lane_engine_if.sv
// Issue/result bus between the vector issue stage and the lane engine.
interface vector_lane_engine_if #(
  parameter int VLEN_BITS = 256,
  parameter int VL_W      = 6
);
  logic                   issue_valid;
  logic                   issue_ready;
  logic [1:0]             vsew;
  logic [VL_W-1:0]        vl;
  logic                   vm;
  logic [2:0]             op;
  logic                   scalar_sel;
  logic [63:0]            rs;
  logic [VLEN_BITS-1:0]   vs1;
  logic [VLEN_BITS-1:0]   vs2;
  logic [VLEN_BITS-1:0]   vs3;
  logic [VLEN_BITS/8-1:0] mask;
  logic                   result_valid;
  logic                   result_ready;
  logic [VLEN_BITS-1:0]   result;

  modport master (
    output issue_valid, vsew, vl, vm, op, scalar_sel, rs, vs1, vs2, vs3, mask, result_ready,
    input  issue_ready, result_valid, result
  );

  modport slave (
    input  issue_valid, vsew, vl, vm, op, scalar_sel, rs, vs1, vs2, vs3, mask, result_ready,
    output issue_ready, result_valid, result
  );
endinterface

// File: rtl/vector_lane_alu.sv
// One element lane: combinational integer op at the selected element width,
// result truncated to SEW. REDSUM decodes as ADD here.
module vector_lane_alu
  import vector_lane_engine_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  op_e         op,
  input  logic [1:0]  sew,
  output logic [63:0] y
);

  logic [63:0] m;
  logic [63:0] am;
  logic [63:0] bm;
  logic [63:0] r;

  // Operands arrive with neighbouring elements in the upper bits, so mask first.
  always_comb begin
    m  = sew_mask(sew);
    am = a & m;
    bm = b & m;
    case (op)
      OP_SUB:  r = bm - am;
      OP_AND:  r = bm & am;
      OP_OR:   r = bm | am;
      OP_XOR:  r = bm ^ am;
      OP_MINU: r = (am < bm) ? am : bm;
      OP_MAXU: r = (am > bm) ? am : bm;
      default: r = bm + am;
    endcase
    y = r & m;
  end

endmodule

// File: rtl/vector_lane_engine.sv
// Multi-lane vector integer engine with mask/tail-undisturbed merge from vs3.
// Optional feature macro: VECTOR_REDUCTION_EN (REDSUM accumulation into element 0).
module vector_lane_engine
  import vector_lane_engine_pkg::*;
#(
  parameter int VLEN_BITS = 256,
  parameter int LANES     = 4,
  parameter int VL_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy_in,
  vector_lane_engine_if.slave  bus
);

  localparam int MASK_W = VLEN_BITS / 8;

  state_e               state;
  logic                 issue_ready_q;
  logic                 result_valid_q;
  logic [1:0]           sew_q;
  logic [VL_W-1:0]      vl_eff_q;
  logic [VL_W-1:0]      idx_q;
  logic                 vm_q;
  op_e                  op_q;
  logic [VLEN_BITS-1:0] a_q;
  logic [VLEN_BITS-1:0] b_q;
  logic [MASK_W-1:0]    mask_q;
  logic [VLEN_BITS-1:0] result_q;
  logic [VLEN_BITS-1:0] next_result;

  int                   max_el;
  logic [VL_W-1:0]      vl_eff_c;
  logic [63:0]          rs_pat;
  logic [VLEN_BITS-1:0] rs_bcast;

  logic [63:0]          ew_mask;
  logic [VLEN_BITS-1:0] ew_vmask;
  int                   ew_bits;
  int                   lane_sh [LANES];
  logic [63:0]          lane_a  [LANES];
  logic [63:0]          lane_b  [LANES];
  logic [63:0]          lane_y  [LANES];
  logic [LANES-1:0]     lane_act;
  logic                 last_grp;
  logic                 is_red;

`ifdef VECTOR_REDUCTION_EN
  logic [63:0]          acc_q;
  logic [63:0]          red_sum;
`endif

  // Clamp vl to the register capacity and replicate rs across every element.
  always_comb begin
    max_el   = VLEN_BITS / (8 << bus.vsew);
    vl_eff_c = (int'(bus.vl) < max_el) ? bus.vl : VL_W'(max_el);
    case (bus.vsew)
      SEW_8:   rs_pat = {8{bus.rs[7:0]}};
      SEW_16:  rs_pat = {4{bus.rs[15:0]}};
      SEW_32:  rs_pat = {2{bus.rs[31:0]}};
      default: rs_pat = bus.rs;
    endcase
    rs_bcast = {(VLEN_BITS/64){rs_pat}};
  end

  // Lane l works on element idx_q+l; its operands are shifted down to bit 0.
  always_comb begin
    ew_mask  = sew_mask(sew_q);
    ew_bits  = 8 * int'(sew_bytes(sew_q));
    ew_vmask = VLEN_BITS'(ew_mask);
    lane_act = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sh[l] = (int'(idx_q) + l) * ew_bits;
      lane_a[l]  = 64'(a_q >> lane_sh[l]);
      lane_b[l]  = 64'(b_q >> lane_sh[l]);
      if ((int'(idx_q) + l) < int'(vl_eff_q))
        lane_act[l] = vm_q | (|(mask_q & (MASK_W'(1) << (int'(idx_q) + l))));
    end
    last_grp = (int'(idx_q) + LANES) >= int'(vl_eff_q);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vector_lane_alu u_alu (
      .a   (lane_a[g]),
      .b   (lane_b[g]),
      .op  (op_q),
      .sew (sew_q),
      .y   (lane_y[g])
    );
  end

  // Merge active lane results into the destination; inactive elements keep vs3.
  always_comb begin
    next_result = result_q;
`ifdef VECTOR_REDUCTION_EN
    is_red  = (op_q == OP_REDSUM);
    red_sum = acc_q;
`else
    is_red  = 1'b0;
`endif
    for (int l = 0; l < LANES; l++) begin
      if (lane_act[l] && !is_red)
        next_result = (next_result & ~(ew_vmask << lane_sh[l])) |
                      ((VLEN_BITS'(lane_y[l]) & ew_vmask) << lane_sh[l]);
`ifdef VECTOR_REDUCTION_EN
      if (lane_act[l])
        red_sum = red_sum + lane_b[l];
`endif
    end
`ifdef VECTOR_REDUCTION_EN
    red_sum = red_sum & ew_mask;
    if (is_red)
      next_result = (next_result & ~ew_vmask) | VLEN_BITS'(red_sum);
`endif
  end

  // Control FSM; rdy_in low freezes everything including both handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      issue_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      idx_q          <= '0;
      vl_eff_q       <= '0;
      sew_q          <= SEW_8;
      vm_q           <= 1'b0;
      op_q           <= OP_ADD;
      a_q            <= '0;
      b_q            <= '0;
      mask_q         <= '0;
`ifdef VECTOR_REDUCTION_EN
      acc_q          <= '0;
`endif
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          if (bus.issue_valid && issue_ready_q) begin
            sew_q         <= bus.vsew;
            vl_eff_q      <= vl_eff_c;
            vm_q          <= bus.vm;
            op_q          <= op_e'(bus.op);
            a_q           <= bus.scalar_sel ? rs_bcast : bus.vs1;
            b_q           <= bus.vs2;
            mask_q        <= bus.mask;
            result_q      <= bus.vs3;
            idx_q         <= '0;
            issue_ready_q <= 1'b0;
`ifdef VECTOR_REDUCTION_EN
            acc_q         <= bus.vs1[63:0] & sew_mask(bus.vsew);
`endif
            if (bus.vl == '0) begin
              state          <= ST_DONE;
              result_valid_q <= 1'b1;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          result_q <= next_result;
          idx_q    <= idx_q + VL_W'(LANES);
`ifdef VECTOR_REDUCTION_EN
          acc_q    <= red_sum;
`endif
          if (last_grp) begin
            state          <= ST_DONE;
            result_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.result_ready) begin
            state          <= ST_IDLE;
            result_valid_q <= 1'b0;
            issue_ready_q  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.issue_ready  = issue_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;

endmodule

// File: tb/tb_vector_lane_engine.sv
// Bench for vector_lane_engine: table of ops checked against an element-level
// model through a result scoreboard, plus stall and reset sequences.
module tb_vector_lane_engine;

  localparam int VLEN = 256;

  typedef struct {
    logic [1:0]   vsew;
    logic [5:0]   vl;
    logic         vm;
    logic [2:0]   op;
    logic         scalar_sel;
    logic [63:0]  rs;
    logic [255:0] vs1;
    logic [255:0] vs2;
    logic [255:0] vs3;
    logic [31:0]  mask;
    int           exp_busy;
    int           chk_el;
    logic [63:0]  chk_val;
  } vec_t;

  logic clk;
  logic rst;
  logic rdy_in;

  vector_lane_engine_if #(.VLEN_BITS(VLEN), .VL_W(6)) bus ();

  vector_lane_engine #(.VLEN_BITS(VLEN), .LANES(4), .VL_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  vec_t         vecs [11];
  logic [255:0] sb_q [$];
  int           total;
  int           bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] el_mask(input logic [1:0] sew);
    int eb;
    eb = 8 << sew;
    return (eb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << eb) - 64'd1);
  endfunction

  function automatic logic [63:0] get_el(input logic [255:0] v, input int i, input logic [1:0] sew);
    return 64'(v >> (i * (8 << sew))) & el_mask(sew);
  endfunction

  function automatic logic [255:0] set_el(input logic [255:0] v, input int i, input logic [1:0] sew,
                                          input logic [63:0] val);
    logic [255:0] m;
    m = 256'(el_mask(sew)) << (i * (8 << sew));
    return (v & ~m) | ((256'(val & el_mask(sew))) << (i * (8 << sew)));
  endfunction

  function automatic logic [255:0] fill_el(input logic [1:0] sew, input logic [63:0] base,
                                           input logic [63:0] step);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 256 / (8 << sew); i++) v = set_el(v, i, sew, base + 64'(i) * step);
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic vec_t mk(input logic [1:0] sew, input logic [5:0] vl, input logic vm,
                              input logic [2:0] op, input logic ss, input logic [63:0] rs,
                              input logic [255:0] a, input logic [255:0] b, input logic [255:0] c,
                              input logic [31:0] mask, input int busy, input int ce,
                              input logic [63:0] cv);
    vec_t t;
    t.vsew = sew; t.vl = vl; t.vm = vm; t.op = op; t.scalar_sel = ss; t.rs = rs;
    t.vs1 = a; t.vs2 = b; t.vs3 = c; t.mask = mask;
    t.exp_busy = busy; t.chk_el = ce; t.chk_val = cv;
    return t;
  endfunction

  // Element-by-element reference of the architected behaviour.
  function automatic logic [255:0] model(input vec_t t);
    int          n;
    int          vle;
    logic [63:0] m;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic [255:0] res;
    n   = 256 / (8 << t.vsew);
    vle = (int'(t.vl) < n) ? int'(t.vl) : n;
    m   = el_mask(t.vsew);
    res = t.vs3;
`ifdef VECTOR_REDUCTION_EN
    if (t.op == 3'd7) begin
      if (t.vl != 0) begin
        r = get_el(t.vs1, 0, t.vsew);
        for (int i = 0; i < vle; i++)
          if (t.vm || t.mask[i]) r = r + get_el(t.vs2, i, t.vsew);
        res = set_el(res, 0, t.vsew, r & m);
      end
      return res;
    end
`endif
    for (int i = 0; i < vle; i++) begin
      if (t.vm || t.mask[i]) begin
        a = t.scalar_sel ? (t.rs & m) : get_el(t.vs1, i, t.vsew);
        b = get_el(t.vs2, i, t.vsew);
        case (t.op)
          3'd1:    r = b - a;
          3'd2:    r = b & a;
          3'd3:    r = b | a;
          3'd4:    r = b ^ a;
          3'd5:    r = (a < b) ? a : b;
          3'd6:    r = (a > b) ? a : b;
          default: r = b + a;
        endcase
        res = set_el(res, i, t.vsew, r & m);
      end
    end
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setFields(input vec_t t);
    bus.vsew       = t.vsew;
    bus.vl         = t.vl;
    bus.vm         = t.vm;
    bus.op         = t.op;
    bus.scalar_sel = t.scalar_sel;
    bus.rs         = t.rs;
    bus.vs1        = t.vs1;
    bus.vs2        = t.vs2;
    bus.vs3        = t.vs3;
    bus.mask       = t.mask;
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the issue edge.
  task automatic driveOp(input vec_t t, input bit push);
    setFields(t);
    bus.issue_valid = 1'b1;
    @(posedge clk);
    if (push) sb_q.push_back(model(t));
    @(negedge clk);
    bus.issue_valid = 1'b0;
  endtask

  task automatic waitResult(input string name, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.result_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, " latency"}, 256'(lat), 256'(exp_lat));
    checkOutput({name, " issue_ready in DONE"}, 256'(bus.issue_ready), 256'(0));
  endtask

  task automatic popCheck(input string name);
    logic [255:0] exp;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got result with empty scoreboard expected queued entry", name);
    end else begin
      exp = sb_q.pop_front();
      checkOutput({name, " result"}, bus.result, exp);
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    checkOutput({name, " back to idle"}, 256'({bus.issue_ready, bus.result_valid}), 256'(2'b10));
  endtask

  task automatic applyStimulus(input vec_t t, input string name);
    driveOp(t, 1'b1);
    waitResult(name, t.exp_busy);
    if (t.chk_el >= 0)
      checkOutput({name, " element"}, 256'(get_el(bus.result, t.chk_el, t.vsew)), 256'(t.chk_val));
    popCheck(name);
  endtask

  initial begin
    total            = 0;
    bad              = 0;
    rst              = 1'b1;
    rdy_in           = 1'b1;
    bus.issue_valid  = 1'b0;
    bus.result_ready = 1'b0;
    setFields(mk(2'd0, 6'd0, 1'b1, 3'd0, 1'b0, 64'd0, '0, '0, '0, '0, 0, -1, 64'd0));

    repeat (2) @(negedge clk);
    checkOutput("reset issue_ready", 256'(bus.issue_ready), 256'(1));
    checkOutput("reset result_valid", 256'(bus.result_valid), 256'(0));
    checkOutput("reset result", bus.result, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    vecs[0]  = mk(2'd2, 6'd8,  1'b1, 3'd0, 1'b0, 64'd0, fill_el(2'd2, 64'd0, 64'd1),
                  fill_el(2'd2, 64'd10, 64'd0), rand256(), 32'h0, 2, 7, 64'd17);
    vecs[1]  = mk(2'd0, 6'd5,  1'b0, 3'd1, 1'b0, 64'd0, fill_el(2'd0, 64'h06, 64'd0),
                  fill_el(2'd0, 64'h05, 64'd0), fill_el(2'd0, 64'hAA, 64'd0), 32'h15, 2, 4, 64'hFF);
    vecs[2]  = mk(2'd0, 6'd0,  1'b1, 3'd0, 1'b0, 64'd0, rand256(), rand256(),
                  fill_el(2'd0, 64'h5A, 64'd0), 32'h0, 0, 0, 64'h5A);
    vecs[3]  = mk(2'd3, 6'd40, 1'b1, 3'd6, 1'b1, 64'd1, rand256(), '0, rand256(), 32'h0, 1, 3, 64'd1);
    vecs[4]  = mk(2'd1, 6'd6,  1'b0, 3'd7, 1'b0, 64'd0, fill_el(2'd1, 64'd100, 64'd0),
                  fill_el(2'd1, 64'd1, 64'd1), fill_el(2'd1, 64'h1234, 64'd0), 32'hFFFF_FFFB, 2, 0,
`ifdef VECTOR_REDUCTION_EN
                  64'd118);
`else
                  64'd101);
`endif
    vecs[5]  = mk(2'd1, 6'd16, 1'b1, 3'd5, 1'b0, 64'd0, rand256(), rand256(), rand256(), 32'h0, 4, -1, 64'd0);
    vecs[6]  = mk(2'd2, 6'd20, 1'b1, 3'd4, 1'b0, 64'd0, rand256(), rand256(), rand256(), 32'h0, 2, -1, 64'd0);
    vecs[7]  = mk(2'd0, 6'd32, 1'b0, 3'd2, 1'b0, 64'd0, rand256(), rand256(), rand256(), $urandom, 8, -1, 64'd0);
    vecs[8]  = mk(2'd3, 6'd3,  1'b1, 3'd3, 1'b0, 64'd0, rand256(), rand256(), rand256(), 32'h0, 1, -1, 64'd0);
    vecs[9]  = mk(2'd0, 6'd63, 1'b1, 3'd0, 1'b0, 64'd0, fill_el(2'd0, 64'hFF, 64'd0),
                  fill_el(2'd0, 64'h02, 64'd0), rand256(), 32'h0, 8, 31, 64'h01);
    vecs[10] = mk(2'd1, 6'd1,  1'b1, 3'd1, 1'b0, 64'd0, fill_el(2'd1, 64'd5, 64'd0),
                  fill_el(2'd1, 64'd3, 64'd0), fill_el(2'd1, 64'h7777, 64'd0), 32'h0, 1, 0, 64'hFFFE);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // An offered op must not be taken while rdy_in is low.
    rdy_in = 1'b0;
    setFields(vecs[0]);
    bus.issue_valid = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("frozen issue not taken", 256'({bus.issue_ready, bus.result_valid}), 256'(2'b10));
    bus.issue_valid = 1'b0;
    rdy_in = 1'b1;
    @(negedge clk);
    checkOutput("idle after frozen offer", 256'({bus.issue_ready, bus.result_valid}), 256'(2'b10));

    // Stall mid-BUSY for 3 cycles, then hold the result for 5 cycles.
    driveOp(vecs[7], 1'b1);
    @(negedge clk);
    rdy_in = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stall valid low", 256'(bus.result_valid), 256'(0));
    checkOutput("stall issue_ready low", 256'(bus.issue_ready), 256'(0));
    rdy_in = 1'b1;
    waitResult("stall", 7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d valid", k), 256'(bus.result_valid), 256'(1));
      checkOutput($sformatf("hold%0d result", k), bus.result, sb_q[0]);
    end
    popCheck("stall");

    // Reset pulse in the middle of an op aborts it with no result.
    driveOp(vecs[9], 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset result", bus.result, 256'(0));
    checkOutput("midreset valid", 256'(bus.result_valid), 256'(0));
    checkOutput("midreset issue_ready", 256'(bus.issue_ready), 256'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(vecs[1], "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_lane_engine.md
Name: vector_lane_engine

Overview:
- Parametrised multi-lane vector execution engine; executes one vector integer op over vl elements at LANES elements per cycle.
- Per-element masking with mask-undisturbed/tail-undisturbed merge from old destination (vs3); valid/ready issue and result handshakes.
- Sits between the vector issue stage and vector register writeback.
- Successor to the fixed 2-lane vector function unit: width, lanes and SEW generalised; handshakes explicit.

Parameters:
- VLEN_BITS, 256, vector register width in bits; multiple of 64.
- LANES, 4, elements processed per BUSY cycle; power of two, 1..VLEN_BITS/8.
- VL_W, 6, vl port width; must hold VLEN_BITS/8 (32 at default).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- rdy_in  in  1  global enable; 0 freezes all state.
- issue_valid  in  1  op presented.
- issue_ready  out  1  engine can accept an op.
- vsew  in  2  element width: 0=8b, 1=16b, 2=32b, 3=64b.
- vl  in  VL_W  active element count.
- vm  in  1  1 = unmasked; 0 = use mask.
- op  in  3  ADD=0, SUB=1, AND=2, OR=3, XOR=4, MINU=5, MAXU=6, REDSUM=7.
- scalar_sel  in  1  1 = operand A is rs broadcast, 0 = vs1.
- rs  in  64  scalar operand; truncated to SEW.
- vs1  in  VLEN_BITS  operand A.
- vs2  in  VLEN_BITS  operand B.
- vs3  in  VLEN_BITS  old destination, used for merge.
- mask  in  VLEN_BITS/8  mask bit i gates element i.
- result_valid  out  1  result held valid.
- result_ready  in  1  consumer accepts result.
- result  out  VLEN_BITS  merged destination vector.

Behaviour:
- Reset: state=IDLE; issue_ready=1; result_valid=0; result=0; index=0; captured operands cleared. Reset asserted mid-op aborts it, with no result produced.
- States:
  - IDLE: issue_ready=1. Handshake (issue_valid&issue_ready&rdy_in) captures all inputs, preloads result register with vs3, then goes to BUSY, or to DONE if vl==0.
  - BUSY: each cycle processes elements index..index+LANES-1, then index+=LANES. When index+LANES>=vl_eff, go to DONE.
  - DONE: result_valid=1; result stable. result_ready&rdy_in -> IDLE. issue_ready=0 in BUSY and DONE.
- vl_eff = min(vl, VLEN_BITS/(8<<vsew)).
  - BUSY lasts ceil(vl_eff/LANES) cycles; result_valid rises the cycle after the last BUSY cycle.
- Element i is written only if i<vl_eff and (vm | mask[i]); otherwise it keeps its vs3 value (tail/mask undisturbed).
- Arithmetic is modulo 2^SEW; SUB = B-A. MINU/MAXU compare unsigned at SEW. Lane outputs are truncated to SEW.
- rdy_in=0: no state, index or result changes; handshakes are not accepted on either side.
- Simultaneous issue_valid during DONE is ignored until IDLE; the minimum op-to-op gap is one IDLE cycle.
- op=7 without VECTOR_REDUCTION_EN behaves as ADD.

Optional Feature:
- Macro: VECTOR_REDUCTION_EN.
- Defined: op=7 (REDSUM) accumulates vs1 element 0 plus all active vs2 elements, modulo 2^SEW, one LANES-group per BUSY cycle. The sum is written to element 0; elements 1.. keep their vs3 value. If no element is active, element 0 = vs1[0].
- Undefined: accumulator logic absent; op=7 decodes as ADD.

Decomposition:
- Shared package: op encodings, SEW encodings, state encodings (IDLE/BUSY/DONE), and a sew_bytes helper function.
- One sub-module: vector_lane_alu (combinational; inputs a, b, op, sew; output 64-bit result). Instantiated LANES times by generate.

Test Plan:
- SEW=32, vl=8, LANES=4, vm=1, ADD, vs1[i]=i, vs2[i]=10 -> 2 BUSY cycles; result[i]=10+i; result_valid in 3rd cycle after issue.
- SEW=8, vl=5, vm=0, mask=0b10101, SUB, vs2=0x05, vs1=0x06, vs3=0xAA -> elements 0,2,4 = 0xFF; elements 1,3 and 5..31 = 0xAA.
- vl=0 -> DONE the cycle after issue; result == vs3; no BUSY cycle.
- SEW=64, vl=40 (clamped to 4), scalar_sel=1, rs=1, MAXU, vs2=0 -> elements 0..3 = 1; 1 BUSY cycle.
- Drop rdy_in for 3 cycles mid-BUSY; hold result_ready=0 for 5 cycles in DONE -> result identical to unstalled run; result_valid and result held stable; rst pulse mid-BUSY -> IDLE, result=0, result_valid=0.
- (VECTOR_REDUCTION_EN) SEW=16, vl=6, REDSUM, vs1[0]=100, vs2[i]=i+1, mask off element 2 -> element 0 = 118; other elements = vs3.
